// File: rtl/trap_pkg.sv
// Shared constants, FSM state type and redirect-target helper for the supervisor trap controller.
// Optional macro TRAP_VECTORED_EN makes stvec[0] writable (vectored interrupt mode).
package trap_pkg;

  localparam logic [11:0] CSR_SSTATUS = 12'h100;
  localparam logic [11:0] CSR_STVEC   = 12'h105;
  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam logic [11:0] CSR_SCAUSE  = 12'h142;

  localparam logic [4:0] CAUSE_ILLEGAL   = 5'd2;
  localparam logic [4:0] CAUSE_ECALL_S   = 5'd9;
  localparam logic [4:0] CAUSE_IRQ_S_EXT = 5'd9;

  localparam int SSTATUS_SIE  = 1;
  localparam int SSTATUS_SPIE = 5;

  // Bits of stvec that hold state; the mode bit only exists in the vectored build.
`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] STVEC_WMASK = 32'hFFFF_FFFD;
`else
  localparam logic [31:0] STVEC_WMASK = 32'hFFFF_FFFC;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAVE   = 2'd1,
    ST_VECTOR = 2'd2,
    ST_RETURN = 2'd3
  } trap_state_e;

  // stvec[0] can only be set when the vectored build is enabled, so this is base-only otherwise.
  function automatic logic [31:0] trap_target(input logic [31:0] stvec,
                                              input logic        is_irq,
                                              input logic [4:0]  cause);
    logic [31:0] base;
    base = stvec & 32'hFFFF_FFFC;
    if (stvec[0] && is_irq) return base + {25'b0, cause, 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/trap_csr_regs.sv
// Supervisor trap CSR storage (sstatus.SIE/SPIE, stvec, sepc, scause) and combinational read mux.
// Honours TRAP_VECTORED_EN through trap_pkg::STVEC_WMASK.
module trap_csr_regs
  import trap_pkg::*;
#(
  parameter logic [31:0] RESET_STVEC = 32'h0000_0100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        save_i,
  input  logic [31:0] save_pc_i,
  input  logic [31:0] save_cause_i,
  input  logic        ret_i,
  output logic [31:0] csr_rdata_o,
  output logic [31:0] stvec_o,
  output logic [31:0] sepc_o,
  output logic        sie_o
);

  logic        sie_q, sie_d;
  logic        spie_q, spie_d;
  logic [31:0] stvec_q, stvec_d;
  logic [31:0] sepc_q, sepc_d;
  logic [31:0] scause_q, scause_d;

  // Trap entry/exit and software writes are mutually exclusive by construction in the FSM.
  always_comb begin
    sie_d    = sie_q;
    spie_d   = spie_q;
    stvec_d  = stvec_q;
    sepc_d   = sepc_q;
    scause_d = scause_q;
    if (save_i) begin
      sepc_d   = save_pc_i & 32'hFFFF_FFFC;
      scause_d = save_cause_i;
      spie_d   = sie_q;
      sie_d    = 1'b0;
    end else if (ret_i) begin
      sie_d  = spie_q;
      spie_d = 1'b1;
    end else if (csr_we_i) begin
      case (csr_addr_i)
        CSR_SSTATUS: begin
          sie_d  = csr_wdata_i[SSTATUS_SIE];
          spie_d = csr_wdata_i[SSTATUS_SPIE];
        end
        CSR_STVEC:  stvec_d  = csr_wdata_i & STVEC_WMASK;
        CSR_SEPC:   sepc_d   = csr_wdata_i & 32'hFFFF_FFFC;
        CSR_SCAUSE: scause_d = csr_wdata_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sie_q    <= 1'b0;
      spie_q   <= 1'b0;
      stvec_q  <= RESET_STVEC & STVEC_WMASK;
      sepc_q   <= '0;
      scause_q <= '0;
    end else begin
      sie_q    <= sie_d;
      spie_q   <= spie_d;
      stvec_q  <= stvec_d;
      sepc_q   <= sepc_d;
      scause_q <= scause_d;
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      CSR_SSTATUS: begin
        csr_rdata_o[SSTATUS_SIE]  = sie_q;
        csr_rdata_o[SSTATUS_SPIE] = spie_q;
      end
      CSR_STVEC:  csr_rdata_o = stvec_q;
      CSR_SEPC:   csr_rdata_o = sepc_q;
      CSR_SCAUSE: csr_rdata_o = scause_q;
      default:    csr_rdata_o = '0;
    endcase
  end

  assign stvec_o = stvec_q;
  assign sepc_o  = sepc_q;
  assign sie_o   = sie_q;

endmodule

// File: rtl/trap_ctrl.sv
// Supervisor trap controller: arbitrates exception / interrupt / sret at commit and sequences
// flush, CSR save/restore and fetch redirect. Macro TRAP_VECTORED_EN enables vectored interrupts.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter logic [31:0] RESET_STVEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        exc_valid,
  input  logic [4:0]  exc_cause,
  input  logic        irq_pending,
  input  logic        sret,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        busy,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  trap_state_e state_q;
  logic [31:0] pc_q;
  logic [4:0]  cause_q;
  logic        irq_q;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;

  logic        idle, sie;
  logic        exc_take, irq_take, ret_take, trap_take;
  logic [31:0] stvec, sepc;

  // Fixed priority: exception, then enabled interrupt, then sret; only one wins per cycle.
  assign idle      = (state_q == ST_IDLE);
  assign exc_take  = idle & exc_valid;
  assign irq_take  = idle & ~exc_valid & irq_pending & sie;
  assign ret_take  = idle & ~exc_valid & ~(irq_pending & sie) & sret;
  assign trap_take = exc_take | irq_take;

  assign flush          = (trap_take | ret_take) & ~rst;
  assign busy           = ~idle;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

  trap_csr_regs #(
    .RESET_STVEC (RESET_STVEC)
  ) u_regs (
    .clk_i        (clk),
    .rst_i        (rst),
    .csr_we_i     (idle & csr_we & ~trap_take & ~ret_take),
    .csr_addr_i   (csr_addr),
    .csr_wdata_i  (csr_wdata),
    .save_i       (state_q == ST_SAVE),
    .save_pc_i    (pc_q),
    .save_cause_i ({irq_q, 26'b0, cause_q}),
    .ret_i        (state_q == ST_RETURN),
    .csr_rdata_o  (csr_rdata),
    .stvec_o      (stvec),
    .sepc_o       (sepc),
    .sie_o        (sie)
  );

  // redirect_valid is loaded on entry to VECTOR/RETURN so it is high for exactly that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      pc_q             <= '0;
      cause_q          <= '0;
      irq_q            <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (trap_take) begin
            state_q <= ST_SAVE;
            pc_q    <= pc;
            cause_q <= exc_take ? exc_cause : CAUSE_IRQ_S_EXT;
            irq_q   <= irq_take;
          end else if (ret_take) begin
            state_q          <= ST_RETURN;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= sepc;
          end
        end
        ST_SAVE: begin
          state_q          <= ST_VECTOR;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= trap_target(stvec, irq_q, cause_q);
        end
        ST_VECTOR: state_q <= ST_IDLE;
        ST_RETURN: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
